ext_pipe: RTL and testbench

- Parametrised, registered successor to the combinational immediate extender.
- Performs immediate extension (sign, zero, upper, branch-shift) and load-data extension (byte/halfword, signed/unsigned, lane-selected by address offset).
- Sits between the decode/MEM stage and its consumer behind a valid/ready handshake with a 2-entry skid buffer.
- Gives 1-cycle latency and full throughput; flags misaligned halfword loads.

---
 rtl/ext_pipe.sv | 145 ++++++++++++++
 tb/tb_ext_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate / load-data extender.
// One-cycle latency, one result per cycle, valid/ready on both sides.
// A main output register (M) plus one skid register (S) absorb a single
// cycle of backpressure without dropping or duplicating results.
module ext_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int OFF_W    = $clog2(OUT_W/8)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] In,
  input  logic [2:0]       Op,
  input  logic [OFF_W-1:0] Off,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] Out,
  output logic             Err
);

  typedef enum logic [2:0] {
    OP_SEXT  = 3'b000,
    OP_ZEXT  = 3'b001,
    OP_UPPER = 3'b010,
    OP_BRANCH= 3'b011,
    OP_LB    = 3'b100,
    OP_LBU   = 3'b101,
    OP_LH    = 3'b110,
    OP_LHU   = 3'b111
  } op_e;

  typedef struct packed {
    logic             err;
    logic [OUT_W-1:0] data;
  } res_t;

  // ---------------------------------------------------------------------
  // Extension datapath (pure function of the presented request)
  // ---------------------------------------------------------------------
  logic [IN_W-1:0]    imm;
  logic [OUT_W-1:0]   imm_sext;
  logic [OFF_W+2:0]   byte_idx;
  logic [OFF_W+2:0]   half_idx;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  res_t               res_new;

  assign imm      = In[IN_W-1:0];
  assign imm_sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  // Byte lanes are little-endian: lane k lives at bits [8k+7:8k].
  assign byte_idx = {Off, 3'b000};
  // Halfword lane is forced even so the slice never runs past the word,
  // even when the request is misaligned (its data is discarded then).
  assign half_idx = {Off[OFF_W-1:1], 1'b0, 3'b000};
  assign ld_byte  = In[byte_idx +: 8];
  assign ld_half  = In[half_idx +: 16];

  // Decode the mode and build the extended result for the incoming request
  always_comb begin
    res_new = '0;
    case (op_e'(Op))
      OP_SEXT:   res_new.data = imm_sext;
      OP_ZEXT:   res_new.data = {{(OUT_W-IN_W){1'b0}}, imm};
      OP_UPPER:  res_new.data = {imm, {(OUT_W-IN_W){1'b0}}};
      OP_BRANCH: res_new.data = imm_sext << BR_SHIFT;
      OP_LB:     res_new.data = {{(OUT_W-8){ld_byte[7]}}, ld_byte};
      OP_LBU:    res_new.data = {{(OUT_W-8){1'b0}}, ld_byte};
      OP_LH: begin
        if (Off[0]) res_new.err  = 1'b1;
        else        res_new.data = {{(OUT_W-16){ld_half[15]}}, ld_half};
      end
      OP_LHU: begin
        if (Off[0]) res_new.err  = 1'b1;
        else        res_new.data = {{(OUT_W-16){1'b0}}, ld_half};
      end
      default:   res_new = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // M / S storage and handshake
  // ---------------------------------------------------------------------
  res_t m_q, m_d, s_q, s_d;
  logic m_vld_q, m_vld_d;
  logic s_vld_q, s_vld_d;
  logic in_ready_q, in_ready_d;
  logic in_xfer;
  logic m_open;

  assign in_xfer = in_valid & in_ready_q;
  // M can take a new value when it is empty or is being drained this edge.
  assign m_open  = ~m_vld_q | out_ready;

  // Next-state for M/S: drain S into M first so FIFO order is preserved
  always_comb begin
    m_d     = m_q;
    m_vld_d = m_vld_q;
    s_d     = s_q;
    s_vld_d = s_vld_q;
    if (m_open) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = in_xfer;
        if (in_xfer) s_d = res_new;
      end else if (in_xfer) begin
        m_d     = res_new;
        m_vld_d = 1'b1;
      end else begin
        // Data is left in place; only the valid bit drops.
        m_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      s_d     = res_new;
      s_vld_d = 1'b1;
    end
    in_ready_d = ~s_vld_d;
  end

  // State registers; reset drops anything in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q        <= '0;
      m_vld_q    <= 1'b0;
      s_q        <= '0;
      s_vld_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      m_vld_q    <= m_vld_d;
      s_q        <= s_d;
      s_vld_q    <= s_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_vld_q;
  assign Out       = m_q.data;
  assign Err       = m_q.err;

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: 32-bit and 64-bit instances, directed
// steps plus randomized traffic scored against an arithmetic model.
module tb_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv_a, ir_a, ov_a, or_a, err_a;
  logic [31:0] in_a, out_a;
  logic [2:0]  op_a;
  logic [1:0]  off_a;

  logic        iv_b, ir_b, ov_b, or_b, err_b;
  logic [63:0] in_b, out_b;
  logic [2:0]  op_b;
  logic [2:0]  off_b;

  ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) u_a (
    .clk(clk), .reset_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .In(in_a),
    .Op(op_a), .Off(off_a), .out_valid(ov_a), .out_ready(or_a), .Out(out_a),
    .Err(err_a));

  ext_pipe #(.IN_W(16), .OUT_W(64), .BR_SHIFT(3)) u_b (
    .clk(clk), .reset_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .In(in_b),
    .Op(op_b), .Off(off_b), .out_valid(ov_b), .out_ready(or_b), .Out(out_b),
    .Err(err_b));

  int checks = 0;
  int errors = 0;
  logic [64:0] q_a[$];
  logic [64:0] q_b[$];

  // Reference: {err, result} from plain integer arithmetic on the mode rules.
  function automatic logic [64:0] model(input logic [63:0] in, input logic [2:0] op,
                                        input int off, input int ow, input int iw,
                                        input int brs);
    logic [63:0] mask;
    longint imm, simm, b, h, r;
    logic err;
    mask = (64'd1 << ow) - 64'd1;
    imm  = longint'(in & ((64'd1 << iw) - 64'd1));
    simm = (imm >= (longint'(1) << (iw - 1))) ? imm - (longint'(1) << iw) : imm;
    b    = longint'((in >> (8 * off)) & 64'hFF);
    h    = longint'((in >> (8 * off)) & 64'hFFFF);
    err  = (op >= 3'd6) && (off % 2 == 1);
    case (op)
      3'd0: r = simm;
      3'd1: r = imm;
      3'd2: r = imm << (ow - iw);
      3'd3: r = simm * (longint'(1) << brs);
      3'd4: r = (b >= 128) ? b - 256 : b;
      3'd5: r = b;
      3'd6: r = err ? 0 : ((h >= 32768) ? h - 65536 : h);
      default: r = err ? 0 : h;
    endcase
    return {err, 64'(r) & mask};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock: score output transfers, enqueue input transfers.
  task automatic tick();
    if (ov_a && or_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb32_extra observed %h expected none", {err_a, out_a});
      end else chk("sb32", {err_a, 32'b0, out_a}, q_a.pop_front());
    end
    if (iv_a && ir_a) q_a.push_back(model(64'(in_a), op_a, int'(off_a), 32, 16, 2));
    if (ov_b && or_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb64_extra observed %h expected none", {err_b, out_b});
      end else chk("sb64", {err_b, out_b}, q_b.pop_front());
    end
    if (iv_b && ir_b) q_b.push_back(model(in_b, op_b, int'(off_b), 64, 16, 3));
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] imm_exp[4];
  logic [2:0]  ld_op[5];
  logic [1:0]  ld_off[5];
  logic [31:0] ld_exp[5];
  logic        ld_err[5];
  logic [31:0] bp_in[5];
  logic [2:0]  bp_op[5];
  logic [1:0]  bp_off[5];

  initial begin
    int sent;
    logic acc_a, acc_b;

    imm_exp = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010};
    ld_op   = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
    ld_off  = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1};
    ld_exp  = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h0};
    ld_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    iv_a = 0; or_a = 0; in_a = '0; op_a = '0; off_a = '0;
    iv_b = 0; or_b = 1; in_b = '0; op_b = '0; off_b = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_out_valid", 65'(ov_a), 65'd0);
    chk("rst_out", 65'(out_a), 65'd0);
    chk("rst_err", 65'(err_a), 65'd0);
    chk("rst_in_ready", 65'(ir_a), 65'd1);
    rst_n = 1'b1;
    tick();

    // Immediate modes, one-cycle latency
    or_a = 1;
    for (int i = 0; i < 4; i++) begin
      iv_a = 1; op_a = 3'(i); off_a = 2'($urandom);
      in_a = ($urandom & 32'hFFFF0000) | 32'h8004;
      tick();
      chk("imm_valid", 65'(ov_a), 65'd1);
      chk("imm_out", {err_a, 32'b0, out_a}, {1'b0, 32'b0, imm_exp[i]});
    end

    // Load modes, including a misaligned halfword
    for (int i = 0; i < 5; i++) begin
      iv_a = 1; op_a = ld_op[i]; off_a = ld_off[i]; in_a = 32'h80FF7F01;
      tick();
      chk("ld_valid", 65'(ov_a), 65'd1);
      chk("ld_out", {err_a, 32'b0, out_a}, {ld_err[i], 32'b0, ld_exp[i]});
    end
    iv_a = 0;
    tick();
    chk("ld_drained", 65'(q_a.size()), 65'd0);

    // Backpressure: 3 stalled cycles, 5 requests, producer holds on !in_ready
    for (int i = 0; i < 5; i++) begin
      bp_in[i] = $urandom; bp_op[i] = 3'($urandom); bp_off[i] = 2'($urandom);
    end
    sent = 0;
    for (int c = 0; c < 40 && sent < 5; c++) begin
      or_a = (c >= 3);
      iv_a = 1; in_a = bp_in[sent]; op_a = bp_op[sent]; off_a = bp_off[sent];
      acc_a = ir_a;
      tick();
      if (acc_a) sent++;
      if (c < 3) begin
        chk("bp_hold_valid", 65'(ov_a), 65'd1);
        chk("bp_hold_out", {err_a, 32'b0, out_a},
            model(64'(bp_in[0]), bp_op[0], int'(bp_off[0]), 32, 16, 2));
      end
      if (c == 1) chk("bp_in_ready_low", 65'(ir_a), 65'd0);
    end
    chk("bp_sent", 65'(sent), 65'd5);
    iv_a = 0; or_a = 1;
    for (int c = 0; c < 10 && q_a.size() != 0; c++) tick();
    chk("bp_drained", 65'(q_a.size()), 65'd0);
    chk("bp_idle", 65'(ov_a), 65'd0);

    // Throughput: 8 back-to-back transfers
    for (int c = 0; c < 8; c++) begin
      iv_a = 1; or_a = 1; in_a = $urandom; op_a = 3'($urandom); off_a = 2'($urandom);
      chk("tp_in_ready", 65'(ir_a), 65'd1);
      tick();
      chk("tp_valid", 65'(ov_a), 65'd1);
    end
    iv_a = 0;
    tick();
    chk("tp_drained", 65'(q_a.size()), 65'd0);

    // 64-bit instance, BR_SHIFT=3
    or_b = 1; iv_b = 1; op_b = 3'd3; off_b = 3'($urandom);
    in_b = {$urandom, $urandom} | 64'hFFFF;
    tick();
    chk("w64_branch", {err_b, out_b}, {1'b0, 64'hFFFFFFFFFFFFFFF8});
    op_b = 3'd5; off_b = 3'd7;
    in_b = {8'hA5, 24'($urandom), $urandom};
    tick();
    chk("w64_lbu", {err_b, out_b}, {1'b0, 64'h00000000000000A5});
    iv_b = 0;
    tick();

    // Random traffic on both instances; held requests stay unchanged
    iv_a = 0; iv_b = 0;
    for (int c = 0; c < 400; c++) begin
      acc_a = iv_a && ir_a;
      acc_b = iv_b && ir_b;
      if (!(iv_a && !acc_a)) begin
        iv_a = $urandom_range(0, 3) != 0; in_a = $urandom;
        op_a = 3'($urandom); off_a = 2'($urandom);
      end
      if (!(iv_b && !acc_b)) begin
        iv_b = $urandom_range(0, 3) != 0; in_b = {$urandom, $urandom};
        op_b = 3'($urandom); off_b = 3'($urandom);
      end
      or_a = $urandom_range(0, 2) != 0;
      or_b = $urandom_range(0, 2) != 0;
      tick();
    end
    iv_a = 0; iv_b = 0; or_a = 1; or_b = 1;
    for (int c = 0; c < 10; c++) tick();
    chk("rnd_drained32", 65'(q_a.size()), 65'd0);
    chk("rnd_drained64", 65'(q_b.size()), 65'd0);

    // Asynchronous reset with M and S both full
    or_a = 0; iv_a = 1; in_a = $urandom; op_a = 3'd1; off_a = 0;
    tick();
    in_a = $urandom;
    tick();
    iv_a = 0;
    chk("full_valid", 65'(ov_a), 65'd1);
    chk("full_in_ready", 65'(ir_a), 65'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 65'(ov_a), 65'd0);
    chk("arst_out", {err_a, 32'b0, out_a}, 65'd0);
    chk("arst_in_ready", 65'(ir_a), 65'd1);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    or_a = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_idle", 65'(ov_a), 65'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
